// File: rtl/pkt_deframer.sv
// pkt_deframer: assembles MSB-first UART bytes into {hdr, loc, data, footer}
// packets, checks header/parity/range and writes good payloads to RAM.
module pkt_deframer #(
   parameter int         LOC_W   = 10,
   parameter int         DATA_W  = 8,
   parameter logic [2:0] HDR     = 3'b101,
   parameter int         DEPTH   = 20,
   parameter int         TIMEOUT = 8000,
   parameter int         CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clear,
   input  logic [7:0]        i_rx_data,
   input  logic              i_rx_valid,
   output logic              o_wr_en,
   output logic [LOC_W-1:0]  o_wr_addr,
   output logic [DATA_W-1:0] o_wr_data,
   output logic [CNT_W-1:0]  o_pkt_count,
   output logic [CNT_W-1:0]  o_err_count,
   output logic              o_err_pulse,
   output logic [1:0]        o_err_code,
   output logic              o_frame_done,
   output logic              o_busy
);

   localparam int NB  = (6 + LOC_W + DATA_W) / 8;
   localparam int PW  = NB * 8 - 3;
   localparam int BW  = $clog2(NB + 1);
   localparam int TW  = $clog2(TIMEOUT + 1);
   localparam int LW1 = LOC_W + 1;

   localparam logic [BW-1:0]    NB_LAST = BW'(NB - 1);
   localparam logic [TW-1:0]    TO_LAST = TW'(TIMEOUT - 1);
   localparam logic [LOC_W:0]   DEPTH_L = LW1'(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   localparam logic [1:0] S_HUNT    = 2'd0;
   localparam logic [1:0] S_COLLECT = 2'd1;
   localparam logic [1:0] S_CHECK   = 2'd2;

   localparam logic [1:0] E_HDR = 2'd0;
   localparam logic [1:0] E_FTR = 2'd1;
   localparam logic [1:0] E_RNG = 2'd2;
   localparam logic [1:0] E_TO  = 2'd3;

   logic [1:0]        r_state;
   logic [PW-1:0]     r_shift;
   logic [BW-1:0]     r_nb;
   logic [TW-1:0]     r_idle;
   logic              r_hold_v;
   logic [7:0]        r_hold;
   logic [CNT_W-1:0]  r_pkt;
   logic [CNT_W-1:0]  r_err;
   logic              r_done;
   logic              r_wr_en;
   logic [LOC_W-1:0]  r_wr_addr;
   logic [DATA_W-1:0] r_wr_data;
   logic              r_err_pulse;
   logic [1:0]        r_err_code;

   logic              w_bv;
   logic [7:0]        w_byte;
   logic              w_hdr_ok;
   logic              w_chk;
   logic              w_to;
   logic              w_start;
   logic              w_hdr_err;
   logic              w_consume;
   logic [PW-1:0]     w_shift_n;
   logic [LOC_W-1:0]  w_loc;
   logic [DATA_W-1:0] w_data;
   logic [2:0]        w_ftr;
   logic [2:0]        w_ftr_exp;
   logic              w_ftr_bad;
   logic              w_rng_bad;
   logic              w_good;
   logic              w_err;
   logic [1:0]        w_code;
   logic [CNT_W-1:0]  w_pkt_inc;
   logic [CNT_W-1:0]  w_err_inc;

   // A byte that could not be taken this cycle waits one cycle in r_hold.
   assign w_bv     = r_hold_v | i_rx_valid;
   assign w_byte   = r_hold_v ? r_hold : i_rx_data;
   assign w_hdr_ok = w_byte[7:5] == HDR;
   assign w_chk    = r_state == S_CHECK;
   assign w_to     = (r_state == S_COLLECT) && (r_idle == TO_LAST);

   assign w_start   = w_bv && w_hdr_ok &&
                      (r_state == S_HUNT || w_chk);
   assign w_hdr_err = w_bv && !w_hdr_ok && r_state == S_HUNT;
   assign w_consume = w_start || w_hdr_err ||
                      (w_bv && r_state == S_COLLECT && !w_to);

   // Header bits fall off the top; only loc/data/footer are kept.
   assign w_shift_n = (r_shift << 8) | PW'(w_byte);

   assign w_loc  = r_shift[PW-1 -: LOC_W];
   assign w_data = r_shift[DATA_W+2:3];
   assign w_ftr  = r_shift[2:0];

   assign w_ftr_exp = {^w_data, ^w_loc,
                       ^{w_data[DATA_W-1:DATA_W/2],
                         w_loc[LOC_W-1:LOC_W/2]}};

   assign w_ftr_bad = w_ftr != w_ftr_exp;
   assign w_rng_bad = {1'b0, w_loc} >= DEPTH_L;
   assign w_good    = w_chk && !w_ftr_bad && !w_rng_bad;
   assign w_err     = w_hdr_err || w_to ||
                      (w_chk && (w_ftr_bad || w_rng_bad));

   assign w_pkt_inc = &r_pkt ? r_pkt : r_pkt + CNT_W'(1);
   assign w_err_inc = &r_err ? r_err : r_err + CNT_W'(1);

   always_comb begin
      if (w_to)
         w_code = E_TO;
      else if (w_chk && w_ftr_bad)
         w_code = E_FTR;
      else if (w_chk)
         w_code = E_RNG;
      else
         w_code = E_HDR;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_HUNT;
         r_shift     <= '0;
         r_nb        <= '0;
         r_idle      <= '0;
         r_hold_v    <= 1'b0;
         r_hold      <= '0;
         r_pkt       <= '0;
         r_err       <= '0;
         r_done      <= 1'b0;
         r_wr_en     <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_err_pulse <= 1'b0;
         r_err_code  <= '0;
      end else if (i_clear) begin
         r_state     <= S_HUNT;
         r_shift     <= '0;
         r_nb        <= '0;
         r_idle      <= '0;
         r_hold_v    <= 1'b0;
         r_pkt       <= '0;
         r_err       <= '0;
         r_done      <= 1'b0;
         r_wr_en     <= 1'b0;
         r_err_pulse <= 1'b0;
      end else begin
         r_wr_en     <= w_good;
         r_err_pulse <= w_err;

         if (w_good) begin
            r_wr_addr <= w_loc;
            r_wr_data <= w_data;
            r_pkt     <= w_pkt_inc;
            if (w_pkt_inc >= DEPTH_C)
               r_done <= 1'b1;
         end

         if (w_err) begin
            r_err      <= w_err_inc;
            r_err_code <= w_code;
         end

         if (w_consume)
            r_hold_v <= r_hold_v && i_rx_valid;
         else if (!r_hold_v)
            r_hold_v <= i_rx_valid;

         if (i_rx_valid && (w_consume == r_hold_v))
            r_hold <= i_rx_data;

         unique case (r_state)
            S_HUNT, S_CHECK: begin
               if (w_start) begin
                  r_shift <= w_shift_n;
                  r_nb    <= BW'(1);
                  r_idle  <= '0;
                  r_state <= (NB == 1) ? S_CHECK : S_COLLECT;
               end else begin
                  r_state <= S_HUNT;
               end
            end
            S_COLLECT: begin
               if (w_to) begin
                  r_state <= S_HUNT;
                  r_nb    <= '0;
                  r_idle  <= '0;
               end else if (w_bv) begin
                  r_shift <= w_shift_n;
                  r_nb    <= r_nb + BW'(1);
                  r_idle  <= '0;
                  if (r_nb == NB_LAST)
                     r_state <= S_CHECK;
               end else begin
                  r_idle <= r_idle + TW'(1);
               end
            end
            default: r_state <= S_HUNT;
         endcase
      end
   end

   assign o_wr_en      = r_wr_en;
   assign o_wr_addr    = r_wr_addr;
   assign o_wr_data    = r_wr_data;
   assign o_pkt_count  = r_pkt;
   assign o_err_count  = r_err;
   assign o_err_pulse  = r_err_pulse;
   assign o_err_code   = r_err_code;
   assign o_frame_done = r_done;
   assign o_busy       = r_state != S_HUNT;

endmodule
